movx_axis: RTL
==============

# movx_axis

Parametrised single-axis movement controller for the PicoBlaze game datapath. It owns a W-bit position register that bounces between configurable limits in STEP increments, one step per `tick`. It pauses at the upper limit, and optionally at the lower limit, until `cont` or a hold timeout. It latches a lost condition on `perdio` and emits one-cycle step-direction pulses on `o_signal` for the display/port logic.

## Interface
- `W`, 8: position width.
- `POS_MIN`, 0: lower limit; start position.
- `POS_MAX`, 200: upper limit; constraint POS_MIN < POS_MAX ≤ 2^W−1.
- `STEP`, 1: increment per tick; constraint 1 ≤ STEP ≤ POS_MAX−POS_MIN.
- `HOLD`, 0: auto-resume delay in cycles at a held limit; 0 means leave only on `cont`.
- `HOLD_LO_EN`, 0: 1 means also hold at POS_MIN; 0 means reverse immediately.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `sta` in 1: start; sampled in IDLE only.
- `tick` in 1: step strobe.
- `cont` in 1: leave a hold state.
- `perdio` in 1: loss event.
- `pos` out W: current position, registered.
- `dir` out 1: 1 = moving up, 0 = moving down.
- `o_signal` out 2: 2'b10 = stepped up, 2'b01 = stepped down, 2'b00 = none. Registered one-cycle pulse.
- `lost` out 1: high while in LOST.
- `state` out 3: current state encoding, for debug.

## Operation
- States: IDLE, UP, DOWN, HOLD_HI, HOLD_LO, LOST.
- Reset (`rst`=0 at a clk edge): state=IDLE, `pos`=POS_MIN, `dir`=1, `o_signal`=00, `lost`=0, hold timer=0. Reset overrides every other input.
- IDLE: `sta` → UP. `tick`, `cont` and `perdio` are ignored.
- UP, checked in priority order:
  - `perdio` → LOST.
  - Else on `tick`: `pos` ← min(`pos`+STEP, POS_MAX) and `o_signal`=10. If the result equals POS_MAX → HOLD_HI.
- DOWN, checked in priority order:
  - `perdio` → LOST.
  - Else on `tick`: `pos` ← max(`pos`−STEP, POS_MIN) and `o_signal`=01. If the result equals POS_MIN → HOLD_LO when HOLD_LO_EN=1, otherwise → UP.
- HOLD_HI / HOLD_LO, checked in priority order:
  - `perdio` → LOST.
  - `cont`, or timer reaching HOLD with HOLD≠0 → DOWN (from HOLD_HI) or UP (from HOLD_LO).
  - `tick` is ignored.
  - The timer clears on entry and counts every cycle in the hold state.
- LOST: absorbing. `lost`=1 and `pos` is frozen until reset.
- `dir` is 1 in UP and HOLD_LO, 0 in DOWN and HOLD_HI. In IDLE and LOST it keeps its last value.
- Arithmetic is done at W+1 bits before the clamp, so there is no wrap-around at 2^W−1 or at 0.

## Timing
- Every output is registered. `tick` sampled at edge n → `pos`, `o_signal` and the new state are visible after edge n.
- `o_signal` is high for exactly one cycle per accepted tick. Back-to-back ticks give back-to-back pulses.
- The step that reaches a limit still pulses. The state enters the hold on the same edge.
- A hold with HOLD=k≠0 and no `cont` lasts exactly k cycles. `cont` in the first hold cycle leaves after 1 cycle.
- Simultaneous events:
  - `perdio`+`tick` → LOST, with no step and no pulse.
  - `perdio`+`cont` → LOST.
  - `cont` on the edge the timer expires → a single exit.

## Structure
- Package `movx_pkg` holds:
  - the state encodings: IDLE=0, UP=1, DOWN=2, HOLD_HI=3, HOLD_LO=4, LOST=5;
  - the `o_signal` codes SIG_NONE, SIG_UP, SIG_DN.
- Sub-module `movx_hold_timer` is a counter with clear, enable and a `done` output at HOLD. Its width is clog2(HOLD+1), and it is tied off when HOLD=0.
- The top level contains the state register, the next-state logic, and the clamped position datapath.

## Test plan
All scenarios use W=4, POS_MIN=2, POS_MAX=9, STEP=3, HOLD=4, HOLD_LO_EN=0 unless stated.
- Reset, then 3 ticks without `sta` → `pos`=2, state=IDLE, `o_signal`=00 throughout.
- `sta`, then 3 ticks → `pos` goes 5, 8, 9 with three 10 pulses; state=HOLD_HI after the third tick.
- In HOLD_HI with no `cont` → DOWN after exactly 4 cycles. Repeat with `cont` in the first cycle → DOWN after 1 cycle; ticks during the hold produce no pulse.
- In DOWN, 3 ticks → `pos` goes 6, 3, 2 with 01 pulses, then UP. With HOLD_LO_EN=1, the state goes to HOLD_LO instead.
- In UP at `pos`=5, assert `perdio` and `tick` together → LOST, `lost`=1, `pos`=5, no pulse. Stays in LOST for 10 cycles with `sta`/`cont`.
- `rst`=0 mid-HOLD_HI with the timer at 2 → next cycle IDLE, `pos`=2, `o_signal`=00, timer=0.

Source files
------------

// File: rtl/movx_pkg.sv
// Shared encodings for the single-axis movement controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package movx_pkg;

  // Controller state encodings; also exported on the debug state port.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_UP      = 3'd1;
  localparam logic [2:0] ST_DOWN    = 3'd2;
  localparam logic [2:0] ST_HOLD_HI = 3'd3;
  localparam logic [2:0] ST_HOLD_LO = 3'd4;
  localparam logic [2:0] ST_LOST    = 3'd5;

  // Step-direction pulse codes driven on o_signal.
  localparam logic [1:0] SIG_NONE = 2'b00;
  localparam logic [1:0] SIG_UP   = 2'b10;
  localparam logic [1:0] SIG_DN   = 2'b01;

  // True for the two limit-hold states, which share the dwell timer.
  function automatic logic is_hold(input logic [2:0] st);
    return (st == ST_HOLD_HI) || (st == ST_HOLD_LO);
  endfunction

endpackage

// File: rtl/movx_hold_timer.sv
// Dwell counter for the limit-hold states; done fires on the HOLD-th hold cycle.
// Latency: done is combinational from the count register and en.
// Backpressure: none; counts every enabled cycle, clears whenever clr is high.
module movx_hold_timer #(
  parameter int unsigned HOLD = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  generate
    if (HOLD == 0) begin : g_off
      // No auto-resume: the hold is left only on cont, so no counter exists.
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clr, en};
      assign done = 1'b0;
    end else begin : g_cnt
      localparam int TW = $clog2(HOLD + 1);
      // Count value seen during the last hold cycle before the exit edge.
      localparam logic [TW-1:0] LAST = TW'(HOLD - 1);

      logic [TW-1:0] cnt_q;
      logic [TW-1:0] cnt_d;

      // Clear outside the hold, count inside it, saturate at the exit value.
      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Count register with synchronous active-low reset.
      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign done = en && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/movx_axis.sv
// Single-axis bouncing position controller with limit holds and a latched loss state.
// Latency: one cycle; every output is registered off the sampling edge.
// Backpressure: none; tick/cont/perdio are level-sampled strobes, never stalled.
module movx_axis
  import movx_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned POS_MIN    = 0,
  parameter int unsigned POS_MAX    = 200,
  parameter int unsigned STEP       = 1,
  parameter int unsigned HOLD       = 0,
  parameter int unsigned HOLD_LO_EN = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sta,
  input  logic         tick,
  input  logic         cont,
  input  logic         perdio,
  output logic [W-1:0] pos,
  output logic         dir,
  output logic [1:0]   o_signal,
  output logic         lost,
  output logic [2:0]   state
);

  // Limits and step at W+1 bits so neither add nor subtract can wrap.
  localparam logic [W:0]   MIN_X  = (W+1)'(POS_MIN);
  localparam logic [W:0]   MAX_X  = (W+1)'(POS_MAX);
  localparam logic [W:0]   STEP_X = (W+1)'(STEP);
  localparam logic [W-1:0] MIN_W  = W'(POS_MIN);
  localparam logic [W-1:0] MAX_W  = W'(POS_MAX);

  logic [2:0]   state_q, state_d;
  logic [W-1:0] pos_q, pos_d;
  logic         dir_q, dir_d;
  logic [1:0]   sig_q, sig_d;
  logic         lost_q, lost_d;

  logic [W:0]   up_sum;
  logic [W:0]   dn_diff;
  logic [W-1:0] up_pos;
  logic [W-1:0] dn_pos;
  logic         in_hold;
  logic         hold_done;

  // Clamped candidate positions for an up step and a down step.
  assign up_sum  = {1'b0, pos_q} + STEP_X;
  assign dn_diff = {1'b0, pos_q} - STEP_X;
  assign up_pos  = (up_sum >= MAX_X) ? MAX_W : up_sum[W-1:0];
  // A borrow out of the top bit means the subtraction went below zero.
  assign dn_pos  = (dn_diff[W] || (dn_diff <= MIN_X)) ? MIN_W : dn_diff[W-1:0];

  // The timer runs only while holding, so it is already zero on every entry.
  assign in_hold = is_hold(state_q);

  movx_hold_timer #(
    .HOLD (HOLD)
  ) u_hold (
    .clk  (clk),
    .rst  (rst),
    .clr  (!in_hold),
    .en   (in_hold),
    .done (hold_done)
  );

  // Next-state, position and pulse selection; perdio outranks every other event.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    sig_d   = SIG_NONE;
    case (state_q)
      ST_IDLE: begin
        if (sta) begin
          state_d = ST_UP;
        end
      end
      ST_UP: begin
        if (perdio) begin
          state_d = ST_LOST;
        end else if (tick) begin
          pos_d = up_pos;
          sig_d = SIG_UP;
          if (up_pos == MAX_W) begin
            state_d = ST_HOLD_HI;
          end
        end
      end
      ST_DOWN: begin
        if (perdio) begin
          state_d = ST_LOST;
        end else if (tick) begin
          pos_d = dn_pos;
          sig_d = SIG_DN;
          if (dn_pos == MIN_W) begin
            state_d = (HOLD_LO_EN != 0) ? ST_HOLD_LO : ST_UP;
          end
        end
      end
      ST_HOLD_HI: begin
        if (perdio) begin
          state_d = ST_LOST;
        end else if (cont || hold_done) begin
          state_d = ST_DOWN;
        end
      end
      ST_HOLD_LO: begin
        if (perdio) begin
          state_d = ST_LOST;
        end else if (cont || hold_done) begin
          state_d = ST_UP;
        end
      end
      ST_LOST: begin
        state_d = ST_LOST;
      end
      default: begin
        // Unused encodings fall back to IDLE rather than lock up.
        state_d = ST_IDLE;
      end
    endcase
  end

  // Direction follows the state being entered; IDLE and LOST keep the last value.
  always_comb begin
    dir_d = dir_q;
    case (state_d)
      ST_UP, ST_HOLD_LO:   dir_d = 1'b1;
      ST_DOWN, ST_HOLD_HI: dir_d = 1'b0;
      default:             dir_d = dir_q;
    endcase
    lost_d = (state_d == ST_LOST);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pos_q   <= MIN_W;
      dir_q   <= 1'b1;
      sig_q   <= SIG_NONE;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      sig_q   <= sig_d;
      lost_q  <= lost_d;
    end
  end

  assign pos      = pos_q;
  assign dir      = dir_q;
  assign o_signal = sig_q;
  assign lost     = lost_q;
  assign state    = state_q;

endmodule
